// File: rtl/round_countdown_timer.sv
// Programmable per-round countdown timer.
// A prescaler turns clk cycles into 1 s ticks, and a seconds counter counts down on each tick.
// Supports start/restart, pause, abort and auto-reload for back-to-back rounds.
// Every output is either a register or a decode of the state register, so no input
// reaches an output combinationally.

module round_countdown_timer #(
    parameter int unsigned TICK_CYCLES = 781250,
    parameter int unsigned SEC_WIDTH   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 abort,
    input  logic                 auto_reload,
    input  logic [SEC_WIDTH-1:0] load_secs,
    output logic [SEC_WIDTH-1:0] secs_left,
    output logic                 tick,
    output logic                 expired,
    output logic                 running,
    output logic                 hit_target
);

    // Prescaler wide enough to hold TICK_CYCLES-1.
    localparam int unsigned PreWidth = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PreWidth-1:0]  PreMax = PreWidth'(TICK_CYCLES - 1);
    localparam logic [SEC_WIDTH-1:0] SecOne = SEC_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [PreWidth-1:0]   prescaler_q, prescaler_d;
    logic [SEC_WIDTH-1:0]  secs_q, secs_d;
    logic [SEC_WIDTH-1:0]  reload_q, reload_d;
    logic                  tick_q, tick_d;
    logic                  expired_q, expired_d;

    // State and datapath registers; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            prescaler_q <= '0;
            secs_q      <= '0;
            reload_q    <= '0;
            tick_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            secs_q      <= secs_d;
            reload_q    <= reload_d;
            tick_q      <= tick_d;
            expired_q   <= expired_d;
        end
    end

    // Next-state logic: abort beats start, and start beats pause/count.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        secs_d      = secs_q;
        reload_d    = reload_q;
        tick_d      = 1'b0;
        expired_d   = 1'b0;

        if (abort) begin
            state_d     = StIdle;
            secs_d      = '0;
            prescaler_d = '0;
        end else if (start) begin
            reload_d    = load_secs;
            prescaler_d = '0;
            if (load_secs != '0) begin
                secs_d  = load_secs;
                state_d = StRun;
            end else begin
                // A zero-length round expires immediately.
                secs_d    = '0;
                state_d   = StDone;
                expired_d = 1'b1;
            end
        end else if ((state_q == StRun) || (state_q == StPaused)) begin
            // Pause is re-sampled every edge, so each paused edge delays expiry by one cycle.
            if (pause) begin
                state_d = StPaused;
            end else begin
                state_d = StRun;
                if (prescaler_q != PreMax) begin
                    prescaler_d = prescaler_q + 1'b1;
                end else begin
                    prescaler_d = '0;
                    tick_d      = 1'b1;
                    if (secs_q > SecOne) begin
                        secs_d = secs_q - SecOne;
                    end else if (auto_reload) begin
                        // Reload directly, so the display never shows 0 between rounds.
                        secs_d    = reload_q;
                        expired_d = 1'b1;
                        state_d   = StRun;
                    end else begin
                        secs_d    = '0;
                        expired_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
        end
    end

    // Outputs come from registers or are decoded from the state register.
    always_comb begin
        secs_left  = secs_q;
        tick       = tick_q;
        expired    = expired_q;
        running    = (state_q == StRun);
        hit_target = (state_q == StIdle) || (state_q == StDone);
    end

endmodule

// File: tb/tb_round_countdown_timer.sv
// Self-checking bench for round_countdown_timer.
// It runs directed scenarios with literal expectations, then randomized traffic.
// A behavioural model, written in terms of seconds and elapsed cycles, is compared
// against the DUT on every cycle.

module tb_round_countdown_timer;

    localparam int TICK = 4;
    localparam int SW   = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic          auto_reload = 1'b0;
    logic [SW-1:0] load_secs = '0;
    logic [SW-1:0] secs_left;
    logic          tick;
    logic          expired;
    logic          running;
    logic          hit_target;

    int n_checks = 0;
    int n_errors = 0;

    round_countdown_timer #(
        .TICK_CYCLES(TICK),
        .SEC_WIDTH  (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .auto_reload(auto_reload),
        .load_secs  (load_secs),
        .secs_left  (secs_left),
        .tick       (tick),
        .expired    (expired),
        .running    (running),
        .hit_target (hit_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int MIdle = 0, MActive = 1, MDone = 2;

    int mode    = MIdle;   // idle / counting / done
    bit m_held  = 1'b0;    // counting but held by pause on the last edge
    int m_secs  = 0;
    int m_elap  = 0;       // advancing cycles spent in the current second
    int m_rel   = 0;
    bit m_tick  = 1'b0;
    bit m_exp   = 1'b0;
    bit m_valid = 1'b0;

    // Model update: each edge, apply the inputs the DUT sees.
    always @(posedge clk) begin : model
        int md, s, e, r;
        bit h, tk, ex;
        md = mode; s = m_secs; e = m_elap; r = m_rel; h = m_held;
        tk = 1'b0; ex = 1'b0;
        if (reset) begin
            md = MIdle; s = 0; e = 0; r = 0; h = 1'b0;
        end else if (abort) begin
            md = MIdle; s = 0; e = 0; h = 1'b0;
        end else if (start) begin
            r = int'(load_secs); e = 0; h = 1'b0;
            if (r == 0) begin
                md = MDone; s = 0; ex = 1'b1;
            end else begin
                md = MActive; s = r;
            end
        end else if (md == MActive) begin
            h = pause;
            if (!pause) begin
                e = e + 1;
                if (e == TICK) begin
                    e = 0;
                    tk = 1'b1;
                    if (s >= 2) begin
                        s = s - 1;
                    end else begin
                        ex = 1'b1;
                        if (auto_reload) s = r;
                        else begin
                            s = 0; md = MDone;
                        end
                    end
                end
            end
        end
        mode <= md; m_secs <= s; m_elap <= e; m_rel <= r; m_held <= h;
        m_tick <= tk; m_exp <= ex;
        if (reset) m_valid <= 1'b1;
    end

    // Compare process: the DUT must match the model on every cycle after reset is seen.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model secs_left", int'(secs_left), m_secs);
            check("model tick", int'(tick), int'(m_tick));
            check("model expired", int'(expired), int'(m_exp));
            check("model running", int'(running), int'(mode == MActive && !m_held));
            check("model hit_target", int'(hit_target), int'(mode != MActive));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the edge that sampled start (E0).
    task automatic pulse_start(input int secs);
        start = 1'b1;
        load_secs = SW'(secs);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cnt;
        // Test 1: reset held with inputs toggling.
        repeat (2) begin
            @(negedge clk);
            start = 1'($urandom);
            abort = 1'($urandom);
            pause = 1'($urandom);
            auto_reload = 1'($urandom);
            load_secs = SW'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; pause = 1'b0; auto_reload = 1'b0;
        check("reset secs_left", int'(secs_left), 0);
        check("reset tick", int'(tick), 0);
        check("reset expired", int'(expired), 0);
        check("reset running", int'(running), 0);
        check("reset hit_target", int'(hit_target), 1);

        // Test 2: 3 s countdown, no reload.
        pulse_start(3);
        check("t2 E0 secs", int'(secs_left), 3);
        check("t2 E0 hit_target", int'(hit_target), 0);
        check("t2 E0 running", int'(running), 1);
        wait_edges(3);
        check("t2 E3 tick", int'(tick), 0);
        wait_edges(1);
        check("t2 E4 tick", int'(tick), 1);
        check("t2 E4 secs", int'(secs_left), 2);
        wait_edges(4);
        check("t2 E8 secs", int'(secs_left), 1);
        wait_edges(4);
        check("t2 E12 expired", int'(expired), 1);
        check("t2 E12 secs", int'(secs_left), 0);
        check("t2 E12 hit_target", int'(hit_target), 1);
        check("t2 E12 running", int'(running), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(expired) + int'(tick);
        end
        check("t2 DONE pulses", cnt, 0);

        // Test 3: pause on E2..E11.
        pulse_start(2);
        wait_edges(1);
        pause = 1'b1;
        wait_edges(1);
        check("t3 E2 running", int'(running), 0);
        wait_edges(9);
        check("t3 E11 secs", int'(secs_left), 2);
        pause = 1'b0;
        wait_edges(3);
        check("t3 E14 tick", int'(tick), 1);
        check("t3 E14 secs", int'(secs_left), 1);
        wait_edges(4);
        check("t3 E18 expired", int'(expired), 1);
        check("t3 E18 secs", int'(secs_left), 0);

        // Test 4: auto-reload.
        auto_reload = 1'b1;
        pulse_start(2);
        wait_edges(8);
        check("t4 E8 expired", int'(expired), 1);
        check("t4 E8 secs", int'(secs_left), 2);
        check("t4 E8 hit_target", int'(hit_target), 0);
        wait_edges(4);
        check("t4 E12 secs", int'(secs_left), 1);
        wait_edges(4);
        check("t4 E16 expired", int'(expired), 1);
        wait_edges(8);
        check("t4 E24 expired", int'(expired), 1);
        auto_reload = 1'b0;
        wait_edges(8);
        check("t4 E32 expired", int'(expired), 1);
        check("t4 E32 secs", int'(secs_left), 0);
        check("t4 E32 hit_target", int'(hit_target), 1);

        // Test 5: abort, abort+start, restart mid-count.
        pulse_start(5);
        wait_edges(5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5 abort secs", int'(secs_left), 0);
        check("t5 abort hit_target", int'(hit_target), 1);
        check("t5 abort running", int'(running), 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += int'(expired);
        end
        check("t5 no expiry after abort", cnt, 0);
        abort = 1'b1;
        start = 1'b1;
        load_secs = 7'd3;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("t5 abort+start hit_target", int'(hit_target), 1);
        check("t5 abort+start secs", int'(secs_left), 0);
        pulse_start(2);
        wait_edges(2);
        pulse_start(4);
        check("t5 restart secs", int'(secs_left), 4);
        wait_edges(3);
        check("t5 restart E3 tick", int'(tick), 0);
        wait_edges(1);
        check("t5 restart E4 tick", int'(tick), 1);
        check("t5 restart E4 secs", int'(secs_left), 3);

        // Test 6: zero-length start, then 1 s from DONE.
        pulse_start(0);
        check("t6 zero expired", int'(expired), 1);
        check("t6 zero secs", int'(secs_left), 0);
        check("t6 zero hit_target", int'(hit_target), 1);
        wait_edges(1);
        check("t6 zero single pulse", int'(expired), 0);
        pulse_start(1);
        wait_edges(3);
        check("t6 1s E3 expired", int'(expired), 0);
        wait_edges(1);
        check("t6 1s E4 expired", int'(expired), 1);
        check("t6 1s E4 secs", int'(secs_left), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
            load_secs = ($urandom_range(0, 9) == 0) ? SW'(0) : SW'($urandom_range(1, 6));
        end
        @(negedge clk);
        reset = 1'b0; abort = 1'b0; start = 1'b0; pause = 1'b0;
        wait_edges(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_countdown_timer.md
Name: round_countdown_timer

Overview:
Programmable per-round countdown timer for the RPS game controller. It replaces the fixed single-shot 60 s timer. The block adds:
- a runtime-loadable duration in seconds,
- pause/resume and abort,
- restart while running,
- an auto-reload mode for back-to-back rounds,
- a live seconds-remaining output for the 7-segment display.

A prescaler converts clk cycles into 1 s ticks. The seconds counter counts down on each tick.

Parameters:
TICK_CYCLES, 781250, clk cycles per 1 s tick (1.28 us clk). Must be >= 2. Benches use 4.
SEC_WIDTH, 7, width of the seconds count (max 127 s).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse: load load_secs and begin counting (also restarts)
pause  in  1  level: freeze prescaler while high
abort  in  1  pulse: return to IDLE, no expiry
auto_reload  in  1  level, sampled at expiry: 1 = reload and continue, 0 = stop
load_secs  in  SEC_WIDTH  duration in seconds, sampled with start
secs_left  out  SEC_WIDTH  seconds remaining (registered)
tick  out  1  1-cycle pulse on each 1 s decrement
expired  out  1  1-cycle pulse when count reaches end
running  out  1  state == RUN
hit_target  out  1  state == IDLE or DONE (timer not active)

Behaviour:
- Reset: clk is the only clock. reset is synchronous, active-high and highest priority. After reset:
  - state = IDLE, prescaler = 0, reload_val = 0
  - secs_left = 0, tick = 0, expired = 0, running = 0, hit_target = 1
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered or decoded from state; no input-to-output combinational paths.
- Priority per edge: reset > abort > start > pause/count.
- abort (any state):
  - state becomes IDLE, secs_left = 0, prescaler = 0.
  - tick and expired are both 0 that cycle.
  - abort together with start: abort wins and start is ignored.
- start (any state, including RUN, PAUSED and DONE):
  - reload_val <= load_secs, prescaler <= 0, no tick on this edge.
  - load_secs != 0: secs_left <= load_secs, state RUN.
  - load_secs == 0: secs_left <= 0, state DONE, expired = 1 for one cycle.
- Advance condition: state in {RUN, PAUSED} and pause == 0. State is RUN when pause is sampled 0 and PAUSED when sampled 1, re-evaluated every edge. A pause held for N edges therefore delays expiry by exactly N cycles.
- On an advance edge:
  - If prescaler != TICK_CYCLES-1: prescaler increments.
  - Otherwise: prescaler <= 0, tick = 1, and then:
    - secs_left > 1: decrement.
    - secs_left == 1 and auto_reload = 1: secs_left <= reload_val, expired = 1, state RUN. secs_left never shows 0 in this case.
    - secs_left == 1 and auto_reload = 0: secs_left <= 0, expired = 1, state DONE. hit_target rises in the same cycle as expired.
- tick and expired are high for exactly one cycle per event. They are 0 on every other edge.
- IDLE and DONE hold all values until start or abort.
- Prescaler width is clog2(TICK_CYCLES). It never exceeds TICK_CYCLES-1.
- secs_left arithmetic is unsigned SEC_WIDTH. No wrap occurs because the decrement stops at 1 → 0/reload.
- Reset mid-count is the same as a power-on reset. No expired pulse.

Test Plan:
(All with TICK_CYCLES=4, SEC_WIDTH=7. E0 = edge sampling start; En = n edges later.)
1. Reset held 2 cycles → secs_left=0, tick=0, expired=0, running=0, hit_target=1. Inputs toggling during reset have no effect.
2. load_secs=3, start at E0, pause=0, auto_reload=0:
   - tick at E4/E8/E12, secs_left 3→2→1→0.
   - expired only at E12, hit_target 0 from E0 until 1 at E12, running falls at E12.
   - Holds DONE for 20 further cycles.
3. load_secs=2, pause sampled high on E2..E11 (10 edges):
   - running=0 during pause, secs_left frozen at 2.
   - ticks at E14/E18, expired at E18.
4. load_secs=2, auto_reload=1:
   - expired at E8/E16/E24, secs_left sequence 2,1,2,1,2; hit_target stays 0.
   - Drop auto_reload before E32 → DONE at E32, secs_left=0.
5. Abort and restart:
   - load_secs=5, abort at E6 → IDLE, secs_left=0, no expired for 40 cycles.
   - abort+start same edge → stays IDLE.
   - start with load_secs=4 at E3 of a running 2 s count → secs_left=4, first tick 4 cycles later.
6. load_secs=0 start → DONE and expired on that edge, one pulse only. A subsequent start with load_secs=1 from DONE → expired 4 cycles later.
